// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: decodes a MIPS instruction, drives ALU inputs, waits, then returns the captured result
module alu_issue_sequencer #(
  parameter int ISSUE_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        branch_taken,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(ISSUE_WAIT - 1);
  state_t state;
  logic [3:0] cnt;
  logic is_beq, is_bne;
  logic legal;
  logic [3:0] op;
  logic [31:0] b;
  logic [4:0] sh;
  logic [5:0] opc, funct;
  logic [31:0] imm_s, imm_z;
  logic unused_fields;
  assign opc = instr[31:26];
  assign funct = instr[5:0];
  assign imm_s = {{16{instr[15]}}, instr[15:0]};
  assign imm_z = {16'd0, instr[15:0]};
  assign unused_fields = ^instr[25:16];
  assign in_ready = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  // Decode opcode/funct into ALU operation, operand B source and shift amount
  always_comb begin
    legal = 1'b1;
    op = 4'd0;
    b = rt_data;
    sh = 5'd0;
    case (opc)
      6'h00: begin
        sh = instr[10:6];
        case (funct)
          6'h20, 6'h21: op = 4'd3;
          6'h22, 6'h23: op = 4'd4;
          6'h24: op = 4'd0;
          6'h25: op = 4'd1;
          6'h27: op = 4'd2;
          6'h00: op = 4'd5;
          6'h02: op = 4'd6;
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin op = 4'd3; b = imm_s; end
      6'h0C: begin op = 4'd0; b = imm_z; end
      6'h0D: begin op = 4'd1; b = imm_z; end
      6'h0F: begin op = 4'd7; b = imm_z; end
      6'h04, 6'h05: op = 4'd4;
      default: legal = 1'b0;
    endcase
  end
  // Issue FSM: accept, hold ALU inputs for ISSUE_WAIT cycles, capture, then hand back
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      is_beq <= 1'b0;
      is_bne <= 1'b0;
      alu_operation <= 4'd0;
      alu_a <= 32'd0;
      alu_b <= 32'd0;
      alu_shamt <= 5'd0;
      result <= 32'd0;
      zero <= 1'b0;
      branch_taken <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (legal) begin
            alu_operation <= op;
            alu_a <= rs_data;
            alu_b <= b;
            alu_shamt <= sh;
            cnt <= 4'd0;
            is_beq <= opc == 6'h04;
            is_bne <= opc == 6'h05;
            state <= ISSUE;
          end else begin
            result <= 32'd0;
            zero <= 1'b0;
            branch_taken <= 1'b0;
            illegal <= 1'b1;
            state <= DONE;
          end
        end
        ISSUE: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            result <= alu_result;
            zero <= alu_zero;
            branch_taken <= is_beq ? alu_zero : (is_bne & ~alu_zero);
            illegal <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: scoreboard bench for the ALU issue sequencer with a behavioural ALU attached
module tb_alu_issue_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0, alu_a, alu_b, alu_result, result;
  logic [3:0] alu_operation;
  logic [4:0] alu_shamt;
  logic alu_zero, zero, branch_taken, illegal;

  logic in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [31:0] instr1 = '0, rs_data1 = '0, rt_data1 = '0, alu_a1, alu_b1, alu_result1, result1;
  logic [3:0] alu_operation1;
  logic [4:0] alu_shamt1;
  logic alu_zero1, zero1, branch_taken1, illegal1;

  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    logic [31:0] r;
    r = op == 4'd0 ? a & b : op == 4'd1 ? a | b : op == 4'd2 ? ~(a | b) : op == 4'd3 ? a + b :
        op == 4'd4 ? a - b : op == 4'd5 ? b << sh : op == 4'd6 ? b >> sh : op == 4'd7 ? b << 16 : 32'd0;
    return {r == 32'd0, r};
  endfunction

  assign {alu_zero, alu_result} = alu_f(alu_operation, alu_a, alu_b, alu_shamt);
  assign {alu_zero1, alu_result1} = alu_f(alu_operation1, alu_a1, alu_b1, alu_shamt1);

  alu_issue_sequencer u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_operation(alu_operation), .alu_a(alu_a),
    .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  alu_issue_sequencer #(.ISSUE_WAIT(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .instr(instr1),
    .rs_data(rs_data1), .rt_data(rt_data1), .alu_operation(alu_operation1), .alu_a(alu_a1),
    .alu_b(alu_b1), .alu_shamt(alu_shamt1), .alu_result(alu_result1), .alu_zero(alu_zero1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1), .zero(zero1),
    .branch_taken(branch_taken1), .illegal(illegal1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] r;
    logic z, br, il;
  } exp_t;
  exp_t sb[$];

  // Monitor: every accepted result is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("mon_result", 64'(result), 64'(e.r));
        chk("mon_flags", 64'({zero, branch_taken, illegal}), 64'({e.z, e.br, e.il}));
      end
    end
  end

  function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  logic [3:0] last_op = '0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [4:0] last_sh = '0;

  task automatic issue(input string nm, input logic [31:0] i, a, bb, input logic [3:0] eop,
                       input logic [31:0] eb, input logic [4:0] esh, input logic [31:0] er,
                       input logic ez, ebr, eil, input int hold);
    int n;
    exp_t e;
    e = {er, ez, ebr, eil};
    if (!eil) begin
      last_op = eop; last_a = a; last_b = eb; last_sh = esh;
    end
    out_ready = (hold == 0);
    instr = i; rs_data = a; rt_data = bb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_alu_op_sh"}, 64'({alu_operation, alu_shamt}), 64'({last_op, last_sh}));
    chk({nm, "_alu_a"}, 64'(alu_a), 64'(last_a));
    chk({nm, "_alu_b"}, 64'(alu_b), 64'(last_b));
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 64'(n), eil ? 64'd1 : 64'd2);
    for (int k = 0; k < hold; k++) begin
      chk({nm, "_hold_out"}, 64'({result, zero, branch_taken, illegal}), 64'(e));
      chk({nm, "_hold_hs"}, 64'({in_ready, out_valid}), 64'b01);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_ready_after"}, 64'({in_ready, out_valid}), 64'b10);
    chk({nm, "_kept"}, 64'({result, zero, branch_taken, illegal}), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", 64'({out_valid, alu_operation, alu_shamt, zero, branch_taken, illegal}), 64'd0);
    chk("rst_data", 64'(alu_a | alu_b | result), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    issue("add",   r_ins(6'h20, 5'd0),  32'd5, 32'd7, 4'd3, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0, 0);
    issue("beq",   i_ins(6'h04, 16'h0010), 32'hDEADBEEF, 32'hDEADBEEF, 4'd4, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 0);
    issue("bne",   i_ins(6'h05, 16'h0010), 32'hDEADBEEF, 32'hDEADBEEF, 4'd4, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    issue("addi",  i_ins(6'h08, 16'hFFFF), 32'd1, 32'd99, 4'd3, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    issue("lui",   i_ins(6'h0F, 16'h1234), 32'd0, 32'd0, 4'd7, 32'h00001234, 5'd0, 32'h12340000, 1'b0, 1'b0, 1'b0, 0);
    issue("sll",   r_ins(6'h00, 5'd4),  32'd0, 32'd1, 4'd5, 32'd1, 5'd4, 32'h10, 1'b0, 1'b0, 1'b0, 0);
    issue("sub",   r_ins(6'h22, 5'd0),  32'd3, 32'd5, 4'd4, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 0);
    issue("nor",   r_ins(6'h27, 5'd0),  32'd0, 32'd0, 4'd2, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0);
    issue("andi",  i_ins(6'h0C, 16'h8F0F), 32'hFFFF00FF, 32'd0, 4'd0, 32'h00008F0F, 5'd0, 32'h0000000F, 1'b0, 1'b0, 1'b0, 0);
    issue("ori",   i_ins(6'h0D, 16'h8000), 32'hF0000000, 32'd0, 4'd1, 32'h00008000, 5'd0, 32'hF0008000, 1'b0, 1'b0, 1'b0, 0);
    issue("srl",   r_ins(6'h02, 5'd31), 32'd0, 32'h80000000, 4'd6, 32'h80000000, 5'd31, 32'd1, 1'b0, 1'b0, 1'b0, 0);
    issue("bne_t", i_ins(6'h05, 16'h0000), 32'd1, 32'd2, 4'd4, 32'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0);
    issue("addu",  r_ins(6'h21, 5'd0),  32'hFFFFFFFF, 32'd1, 4'd3, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    issue("or_bp", r_ins(6'h25, 5'd0),  32'h0F, 32'hF0, 4'd1, 32'hF0, 5'd0, 32'hFF, 1'b0, 1'b0, 1'b0, 5);
    issue("illop", i_ins(6'h3F, 16'h0000), 32'd1, 32'd2, 4'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
    issue("illfn", r_ins(6'h3F, 5'd0),  32'd1, 32'd2, 4'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
    issue("lw",    i_ins(6'h23, 16'h8000), 32'h00010000, 32'd0, 4'd3, 32'hFFFF8000, 5'd0, 32'h00008000, 1'b0, 1'b0, 1'b0, 0);
    issue("sw",    i_ins(6'h2B, 16'h0004), 32'd8, 32'd0, 4'd3, 32'd4, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0, 0);

    instr1 = r_ins(6'h20, 5'd0); rs_data1 = 32'd5; rt_data1 = 32'd7; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("w4_mid_issue", 64'({in_ready1, out_valid1, alu_operation1}), 64'({2'b00, 4'd3}));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("w4_rst_outs", 64'({in_ready1, out_valid1, alu_operation1, alu_shamt1, zero1, branch_taken1, illegal1}), 64'd0);
    chk("w4_rst_data", 64'(alu_a1 | alu_b1 | result1), 64'd0);
    reset = 1'b0;
    #1;
    chk("w4_rst_release_ready", 64'(in_ready1), 64'd1);
    instr1 = r_ins(6'h20, 5'd0); rs_data1 = 32'd100; rt_data1 = 32'd23; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 1;
    while (!out_valid1 && n < 30) begin @(posedge clk); #1; n++; end
    chk("w4_latency", 64'(n), 64'd5);
    chk("w4_result", 64'({result1, zero1, branch_taken1, illegal1}), 64'({32'd123, 3'b000}));
    @(posedge clk); #1;
    chk("w4_ready_after", 64'({in_ready1, out_valid1}), 64'b10);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
